step_dir_decoder_xy: RTL

- Receiving end of the two-axis step/dir interface.
- Decodes step pulses plus direction levels for X and Y into signed absolute positions and per-move signed step counts.
- Detects end of move by an idle timeout measured in clk_en ticks and reports each completed move with a one-cycle valid strobe.
- Sits in the processor as a closed-loop position tracker and as the checker/monitor for the XY stepper controller in benches.

---
 rtl/step_dir_decoder_xy.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/step_dir_decoder_xy.sv
// Two-axis step/dir receiver: tracks absolute X/Y positions and reports per-move step counts.
// Optional sticky range checking is built when STEP_DIR_DECODER_LIMITS_EN is defined.
module step_dir_decoder_xy #(
    parameter int unsigned POS_BITS     = 16,
    parameter int unsigned COUNT_BITS_X = 8,
    parameter int unsigned COUNT_BITS_Y = 8,
    parameter int unsigned IDLE_TICKS   = 16
`ifdef STEP_DIR_DECODER_LIMITS_EN
    ,
    parameter int unsigned LIMIT_X = (2 ** (POS_BITS - 1)) - 1,
    parameter int unsigned LIMIT_Y = (2 ** (POS_BITS - 1)) - 1
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    clear,
    input  logic                    in_x,
    input  logic                    dir_x,
    input  logic                    in_y,
    input  logic                    dir_y,
    output logic [POS_BITS-1:0]     pos_x,
    output logic [POS_BITS-1:0]     pos_y,
    output logic [COUNT_BITS_X-1:0] move_steps_x,
    output logic [COUNT_BITS_Y-1:0] move_steps_y,
    output logic                    move_valid,
    output logic                    busy
`ifdef STEP_DIR_DECODER_LIMITS_EN
    ,
    output logic                    limit_err_x,
    output logic                    limit_err_y
`endif
);

    localparam int unsigned TimerBits = $clog2(IDLE_TICKS + 1);
    localparam logic [TimerBits-1:0] TimerEnd = TimerBits'(IDLE_TICKS);

    // Counts saturate symmetrically; the most negative code is never produced.
    localparam logic [COUNT_BITS_X-1:0] CntMaxX = {1'b0, {(COUNT_BITS_X - 1){1'b1}}};
    localparam logic [COUNT_BITS_X-1:0] CntMinX = ~CntMaxX + COUNT_BITS_X'(1);
    localparam logic [COUNT_BITS_Y-1:0] CntMaxY = {1'b0, {(COUNT_BITS_Y - 1){1'b1}}};
    localparam logic [COUNT_BITS_Y-1:0] CntMinY = ~CntMaxY + COUNT_BITS_Y'(1);

    typedef enum logic [1:0] {StIdle, StMoving, StReport} state_e;

    state_e                  state_q, state_d;
    logic [TimerBits-1:0]    timer_q, timer_d;
    logic                    prev_x_q, prev_y_q;
    logic [POS_BITS-1:0]     pos_x_q, pos_y_q, pos_x_nxt, pos_y_nxt;
    logic [COUNT_BITS_X-1:0] cnt_x_q, cnt_x_d, steps_x_q;
    logic [COUNT_BITS_Y-1:0] cnt_y_q, cnt_y_d, steps_y_q;
    logic                    step_x, step_y, any_step, report_now;

    assign step_x    = in_x & ~prev_x_q;
    assign step_y    = in_y & ~prev_y_q;
    assign any_step  = step_x | step_y;
    assign pos_x_nxt = dir_x ? pos_x_q - POS_BITS'(1) : pos_x_q + POS_BITS'(1);
    assign pos_y_nxt = dir_y ? pos_y_q - POS_BITS'(1) : pos_y_q + POS_BITS'(1);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        report_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_step) begin
                    state_d = StMoving;
                    timer_d = '0;
                end
            end
            StMoving: begin
                // A step on the timeout cycle keeps the move alive.
                if (any_step) begin
                    timer_d = '0;
                end else if (clk_en) begin
                    timer_d = timer_q + TimerBits'(1);
                    if (timer_d == TimerEnd) begin
                        state_d    = StReport;
                        timer_d    = '0;
                        report_now = 1'b1;
                    end
                end
            end
            StReport: begin
                state_d = any_step ? StMoving : StIdle;
                timer_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        if (report_now) begin
            cnt_x_d = '0;
            cnt_y_d = '0;
        end else begin
            if (step_x && !dir_x && cnt_x_q != CntMaxX) cnt_x_d = cnt_x_q + COUNT_BITS_X'(1);
            if (step_x && dir_x && cnt_x_q != CntMinX)  cnt_x_d = cnt_x_q - COUNT_BITS_X'(1);
            if (step_y && !dir_y && cnt_y_q != CntMaxY) cnt_y_d = cnt_y_q + COUNT_BITS_Y'(1);
            if (step_y && dir_y && cnt_y_q != CntMinY)  cnt_y_d = cnt_y_q - COUNT_BITS_Y'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x_q <= in_x;
            prev_y_q <= in_y;
        end else begin
            prev_x_q <= in_x;
            prev_y_q <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            cnt_x_q   <= '0;
            cnt_y_q   <= '0;
            steps_x_q <= '0;
            steps_y_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            if (step_x) pos_x_q <= pos_x_nxt;
            if (step_y) pos_y_q <= pos_y_nxt;
            if (report_now) begin
                steps_x_q <= cnt_x_q;
                steps_y_q <= cnt_y_q;
            end
        end
    end

`ifdef STEP_DIR_DECODER_LIMITS_EN
    localparam logic [POS_BITS-1:0] LimX = POS_BITS'(LIMIT_X);
    localparam logic [POS_BITS-1:0] LimY = POS_BITS'(LIMIT_Y);

    logic lim_x_q, lim_y_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lim_x_q <= 1'b0;
            lim_y_q <= 1'b0;
        end else begin
            // Negative positions show up as a set sign bit.
            if (step_x && (pos_x_nxt[POS_BITS-1] || pos_x_nxt > LimX)) lim_x_q <= 1'b1;
            if (step_y && (pos_y_nxt[POS_BITS-1] || pos_y_nxt > LimY)) lim_y_q <= 1'b1;
        end
    end

    assign limit_err_x = lim_x_q;
    assign limit_err_y = lim_y_q;
`endif

    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;
    assign move_steps_x = steps_x_q;
    assign move_steps_y = steps_y_q;
    assign move_valid   = (state_q == StReport);
    assign busy         = (state_q == StMoving);

endmodule
